// File: rtl/pio_irq_servicer_if.sv
// pio_irq_servicer_if: bus bundle between the PIO interrupt servicer and its
// environment.
//   PIO side : pio_irq, pio_address, pio_chipselect, pio_write_n,
//              pio_writedata, pio_readdata (registered read, 1-cycle latency)
//   Config   : cfg_valid / cfg_mask / cfg_ready (mask-update handshake)
//   Events   : evt_valid / evt_data / evt_ready, ovf_count (lost events)
// Modports: master = servicer view, slave = PIO + consumer view.
`timescale 1ns/1ps
interface pio_irq_servicer_if #(
  parameter int unsigned DATA_W = 4
);
  localparam int unsigned BUS_W  = 32;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned OVF_W  = 8;

  logic                pio_irq;
  logic [ADDR_W-1:0]   pio_address;
  logic                pio_chipselect;
  logic                pio_write_n;
  logic [BUS_W-1:0]    pio_writedata;
  logic [BUS_W-1:0]    pio_readdata;

  logic                cfg_valid;
  logic [DATA_W-1:0]   cfg_mask;
  logic                cfg_ready;

  logic                evt_valid;
  logic [DATA_W-1:0]   evt_data;
  logic                evt_ready;
  logic [OVF_W-1:0]    ovf_count;

  modport master (
    input  pio_irq, pio_readdata, cfg_valid, cfg_mask, evt_ready,
    output pio_address, pio_chipselect, pio_write_n, pio_writedata,
           cfg_ready, evt_valid, evt_data, ovf_count
  );

  modport slave (
    output pio_irq, pio_readdata, cfg_valid, cfg_mask, evt_ready,
    input  pio_address, pio_chipselect, pio_write_n, pio_writedata,
           cfg_ready, evt_valid, evt_data, ovf_count
  );
endinterface

// File: rtl/pio_irq_servicer.sv
// pio_irq_servicer: services a PIO edge-capture interrupt. After reset it
// programs the PIO irq mask, then on each interrupt reads edge_capture,
// clears the captured bits and merges them into a pending-event register
// offered to a consumer. Mask updates arrive through a one-deep request slot.
// Ports:
//   clk      : single clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : pio_irq_servicer_if.master (PIO bus, cfg and event handshakes)
`timescale 1ns/1ps
module pio_irq_servicer #(
  parameter int unsigned          DATA_W    = 4,
  parameter logic [DATA_W-1:0]    INIT_MASK = DATA_W'(4'hF)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pio_irq_servicer_if.master   bus
);
  localparam int unsigned BUS_W  = 32;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned OVF_W  = 8;

  localparam logic [ADDR_W-1:0] ADDR_NONE = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_CAP  = ADDR_W'(3);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CFG,
    S_RD_REQ,
    S_RD_CAP,
    S_CLR,
    S_HOLD
  } state_t;

  state_t              state;
  logic                init_done;
  logic                cs;
  logic                write_n;
  logic [ADDR_W-1:0]   address;
  logic [BUS_W-1:0]    writedata;
  logic [DATA_W-1:0]   cap;
  logic [DATA_W-1:0]   shadow;
  logic                cfg_pend;
  logic [DATA_W-1:0]   pend;
  logic [OVF_W-1:0]    ovf_count;

  logic [DATA_W-1:0]   rd_cap;
  logic                accepted;
  logic                cfg_accept;

  assign rd_cap     = bus.pio_readdata[DATA_W-1:0];
  assign accepted   = (|pend) && bus.evt_ready;
  assign cfg_accept = bus.cfg_valid && !cfg_pend;

  assign bus.pio_chipselect = cs;
  assign bus.pio_write_n    = write_n;
  assign bus.pio_address    = address;
  assign bus.pio_writedata  = writedata;
  assign bus.cfg_ready      = !cfg_pend;
  assign bus.evt_valid      = |pend;
  assign bus.evt_data       = pend;
  assign bus.ovf_count      = ovf_count;

  // Control FSM; bus outputs are registered alongside the state they belong to.
  // INIT spends its first cycle after reset idle on the bus (the reset values),
  // then drives the mask write for one cycle, tracked by init_done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_INIT;
      init_done <= 1'b0;
      cs        <= 1'b0;
      write_n   <= 1'b1;
      address   <= ADDR_NONE;
      writedata <= '0;
      cap       <= '0;
      shadow    <= INIT_MASK;
      cfg_pend  <= 1'b0;
    end else begin
      cs        <= 1'b0;
      write_n   <= 1'b1;
      address   <= ADDR_NONE;
      writedata <= '0;

      // Only accepted while the slot is empty, so it never races the CFG clear.
      if (cfg_accept) begin
        shadow   <= bus.cfg_mask;
        cfg_pend <= 1'b1;
      end

      case (state)
        S_INIT: begin
          if (!init_done) begin
            init_done <= 1'b1;
            cs        <= 1'b1;
            write_n   <= 1'b0;
            address   <= ADDR_MASK;
            writedata <= BUS_W'(INIT_MASK);
          end else begin
            state <= S_IDLE;
          end
        end

        S_IDLE: begin
          // A queued mask update has priority over servicing the interrupt.
          if (cfg_pend) begin
            state     <= S_CFG;
            cfg_pend  <= 1'b0;
            cs        <= 1'b1;
            write_n   <= 1'b0;
            address   <= ADDR_MASK;
            writedata <= BUS_W'(shadow);
          end else if (bus.pio_irq) begin
            state   <= S_RD_REQ;
            cs      <= 1'b1;
            address <= ADDR_CAP;
          end
        end

        S_CFG: begin
          state <= S_HOLD;
        end

        S_RD_REQ: begin
          state   <= S_RD_CAP;
          cs      <= 1'b1;
          address <= ADDR_CAP;
        end

        S_RD_CAP: begin
          cap <= rd_cap;
          // Spurious interrupt (nothing captured): skip the clearing write.
          if (|rd_cap) begin
            state     <= S_CLR;
            cs        <= 1'b1;
            write_n   <= 1'b0;
            address   <= ADDR_CAP;
            writedata <= BUS_W'(rd_cap);
          end else begin
            state <= S_HOLD;
          end
        end

        S_CLR: begin
          state <= S_HOLD;
        end

        // One dead cycle lets the PIO drop irq before IDLE samples it again.
        S_HOLD: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

  // Pending events and lost-event counter. The capture merges into pend in
  // the RD_CAP cycle straight from the read data, so events appear one cycle
  // after the read returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend      <= '0;
      ovf_count <= '0;
    end else if (state == S_RD_CAP) begin
      pend <= (accepted ? '0 : pend) | rd_cap;
      if (!accepted && (|(pend & rd_cap)) && (ovf_count != '1)) begin
        ovf_count <= ovf_count + OVF_W'(1);
      end
    end else if (accepted) begin
      pend <= '0;
    end
  end

endmodule

// File: tb/tb_pio_irq_servicer.sv
// tb_pio_irq_servicer: directed bench for pio_irq_servicer with a behavioural
// PIO (rising-edge capture, write-1-to-clear, registered reads) and a
// cycle-by-cycle vector table plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_pio_irq_servicer;
  localparam int unsigned DATA_W = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pio_irq_servicer_if #(.DATA_W(DATA_W)) bus ();

  pio_irq_servicer #(.DATA_W(DATA_W), .INIT_MASK(4'hF)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  // ---------------- PIO model ----------------
  logic [3:0]  btn;
  logic [3:0]  btn_q;
  logic [3:0]  ec;
  logic [3:0]  mask;
  logic        spur;
  int unsigned n_writes;
  logic        wr_cap;

  assign wr_cap = bus.pio_chipselect && !bus.pio_write_n && (bus.pio_address == 2'd3);
  assign bus.pio_irq = spur | (|(ec & mask));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q            <= 4'h0;
      ec               <= 4'h0;
      mask             <= 4'h0;
      bus.pio_readdata <= 32'h0;
      n_writes         <= 0;
    end else begin
      btn_q <= btn;
      ec    <= (ec & ~(wr_cap ? bus.pio_writedata[3:0] : 4'h0)) | (btn & ~btn_q);
      if (bus.pio_chipselect && !bus.pio_write_n) begin
        n_writes <= n_writes + 1;
        if (bus.pio_address == 2'd2) mask <= bus.pio_writedata[3:0];
      end
      if (bus.pio_chipselect && bus.pio_write_n) begin
        if (spur)                         bus.pio_readdata <= 32'h0;
        else if (bus.pio_address == 2'd3) bus.pio_readdata <= {28'h0, ec};
        else if (bus.pio_address == 2'd2) bus.pio_readdata <= {28'h0, mask};
        else                              bus.pio_readdata <= 32'h0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] obs_bus();
    return 64'({bus.pio_chipselect, bus.pio_write_n, bus.pio_address, bus.pio_writedata});
  endfunction

  function automatic logic [63:0] obs_evt();
    return 64'({bus.evt_valid, bus.evt_data, bus.ovf_count});
  endfunction

  function automatic logic [63:0] pk_bus(input logic c, input logic w, input logic [1:0] a,
                                         input logic [31:0] d);
    return 64'({c, w, a, d});
  endfunction

  function automatic logic [63:0] pk_evt(input logic v, input logic [3:0] d, input logic [7:0] o);
    return 64'({v, d, o});
  endfunction

  // Edge on the given buttons, then let the whole service sequence finish.
  task automatic pulse(input logic [3:0] b);
    btn = b;
    tick();
    btn = 4'h0;
    repeat (6) tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  btn;
    logic        rdy;
    logic        cv;
    logic [3:0]  cm;
    logic        cs;
    logic        wn;
    logic [1:0]  a;
    logic [31:0] wd;
    logic        ev;
    logic [3:0]  ed;
    logic        crdy;
    logic        irq;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic [3:0] b, input logic r, input logic cv,
                              input logic [3:0] cm, input logic cs, input logic wn,
                              input logic [1:0] a, input logic [31:0] wd, input logic ev,
                              input logic [3:0] ed, input logic crdy, input logic irq);
    vec_t v;
    v.btn = b; v.rdy = r; v.cv = cv; v.cm = cm;
    v.cs = cs; v.wn = wn; v.a = a; v.wd = wd;
    v.ev = ev; v.ed = ed; v.crdy = crdy; v.irq = irq;
    return v;
  endfunction

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] act;
    logic [63:0] exp;
    int unsigned w_before;

    // Bit-2 edge serviced with ready=1, then a cfg update racing a bit-0 edge.
    vecs[0]  = mk(4'h4, 1, 0, 4'h0,  0, 1, 2'd0, 32'h0,  0, 4'h0, 1, 1);
    vecs[1]  = mk(4'h4, 1, 0, 4'h0,  1, 1, 2'd3, 32'h0,  0, 4'h0, 1, 1);
    vecs[2]  = mk(4'h4, 1, 0, 4'h0,  1, 1, 2'd3, 32'h0,  0, 4'h0, 1, 1);
    vecs[3]  = mk(4'h4, 1, 0, 4'h0,  1, 0, 2'd3, 32'h4,  1, 4'h4, 1, 1);
    vecs[4]  = mk(4'h4, 1, 0, 4'h0,  0, 1, 2'd0, 32'h0,  0, 4'h0, 1, 0);
    vecs[5]  = mk(4'h4, 1, 0, 4'h0,  0, 1, 2'd0, 32'h0,  0, 4'h0, 1, 0);
    vecs[6]  = mk(4'h0, 1, 0, 4'h0,  0, 1, 2'd0, 32'h0,  0, 4'h0, 1, 0);
    vecs[7]  = mk(4'h1, 1, 1, 4'h5,  0, 1, 2'd0, 32'h0,  0, 4'h0, 0, 1);
    vecs[8]  = mk(4'h1, 1, 0, 4'h0,  1, 0, 2'd2, 32'h5,  0, 4'h0, 1, 1);
    vecs[9]  = mk(4'h1, 1, 0, 4'h0,  0, 1, 2'd0, 32'h0,  0, 4'h0, 1, 1);
    vecs[10] = mk(4'h1, 1, 0, 4'h0,  0, 1, 2'd0, 32'h0,  0, 4'h0, 1, 1);
    vecs[11] = mk(4'h1, 1, 0, 4'h0,  1, 1, 2'd3, 32'h0,  0, 4'h0, 1, 1);
    vecs[12] = mk(4'h1, 1, 0, 4'h0,  1, 1, 2'd3, 32'h0,  0, 4'h0, 1, 1);
    vecs[13] = mk(4'h1, 1, 0, 4'h0,  1, 0, 2'd3, 32'h1,  1, 4'h1, 1, 1);
    vecs[14] = mk(4'h1, 1, 0, 4'h0,  0, 1, 2'd0, 32'h0,  0, 4'h0, 1, 0);
    vecs[15] = mk(4'h0, 1, 0, 4'h0,  0, 1, 2'd0, 32'h0,  0, 4'h0, 1, 0);

    btn = 4'h0;
    spur = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_mask  = 4'h0;
    bus.evt_ready = 1'b1;

    // Reset values while held in reset.
    repeat (2) @(negedge clk);
    chk("reset_bus", obs_bus(), pk_bus(0, 1, 2'd0, 32'h0));
    chk("reset_evt", 64'({bus.evt_valid, bus.cfg_ready, bus.ovf_count}), 64'({1'b0, 1'b1, 8'h0}));

    // First cycle after release: INIT mask write, then idle.
    reset_n = 1'b1;
    tick();
    chk("init_write", obs_bus(), pk_bus(1, 0, 2'd2, 32'h0000_000F));
    tick();
    chk("init_idle", obs_bus(), pk_bus(0, 1, 2'd0, 32'h0));
    chk("init_evt", 64'(bus.evt_valid), 64'(0));

    for (int i = 0; i < 16; i++) begin
      btn           = vecs[i].btn;
      bus.evt_ready = vecs[i].rdy;
      bus.cfg_valid = vecs[i].cv;
      bus.cfg_mask  = vecs[i].cm;
      tick();
      act = 64'({bus.pio_chipselect, bus.pio_write_n, bus.pio_address, bus.pio_writedata,
                 bus.evt_valid, bus.evt_data, bus.cfg_ready, bus.pio_irq});
      exp = 64'({vecs[i].cs, vecs[i].wn, vecs[i].a, vecs[i].wd,
                 vecs[i].ev, vecs[i].ed, vecs[i].crdy, vecs[i].irq});
      chk($sformatf("vec%0d", i), act, exp);
    end
    bus.cfg_valid = 1'b0;

    // Reset asserted in the CLR cycle aborts the write at once; INIT reruns.
    btn = 4'h1;
    tick();
    btn = 4'h0;
    repeat (3) tick();
    chk("clr_reached", obs_bus(), pk_bus(1, 0, 2'd3, 32'h1));
    reset_n = 1'b0;
    #1;
    chk("abort_bus", obs_bus(), pk_bus(0, 1, 2'd0, 32'h0));
    chk("abort_evt", 64'({bus.evt_valid, bus.cfg_ready, bus.ovf_count}), 64'({1'b0, 1'b1, 8'h0}));
    @(negedge clk);
    tick();
    reset_n = 1'b1;
    tick();
    chk("reinit_write", obs_bus(), pk_bus(1, 0, 2'd2, 32'h0000_000F));
    tick();

    // Merging with consumer stalled: overlapping bit counts as lost.
    bus.evt_ready = 1'b0;
    pulse(4'h1);
    chk("merge_b0", obs_evt(), pk_evt(1, 4'h1, 8'd0));
    pulse(4'h2);
    chk("merge_b1", obs_evt(), pk_evt(1, 4'h3, 8'd0));
    pulse(4'h1);
    chk("merge_ovf", obs_evt(), pk_evt(1, 4'h3, 8'd1));
    bus.evt_ready = 1'b1;
    tick();
    chk("drain", obs_evt(), pk_evt(0, 4'h0, 8'd1));

    // Spurious interrupt: read returns 0, no clearing write, straight to HOLD.
    bus.evt_ready = 1'b0;
    pulse(4'h4);
    chk("pend_b2", obs_evt(), pk_evt(1, 4'h4, 8'd1));
    w_before = n_writes;
    spur = 1'b1;
    tick();
    chk("spur_rdreq", obs_bus(), pk_bus(1, 1, 2'd3, 32'h0));
    tick();
    chk("spur_rdcap", obs_bus(), pk_bus(1, 1, 2'd3, 32'h0));
    tick();
    chk("spur_hold", obs_bus(), pk_bus(0, 1, 2'd0, 32'h0));
    chk("spur_evt", obs_evt(), pk_evt(1, 4'h4, 8'd1));
    spur = 1'b0;
    repeat (2) tick();
    chk("spur_nowrite", 64'(n_writes), 64'(w_before));

    // Lost-event counter saturates.
    repeat (260) pulse(4'h4);
    chk("ovf_sat", obs_evt(), pk_evt(1, 4'h4, 8'd255));
    bus.evt_ready = 1'b1;
    tick();
    chk("sat_drain", obs_evt(), pk_evt(0, 4'h0, 8'd255));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
